// File: rtl/ysyx_23060025_axi_sram_resp.sv
// AXI4-Lite style SRAM responder: one outstanding transaction, programmable response latency.
// Optional `SRAM_RAND_DELAY_EN`: LFSR-driven latency and post-response idle cycles.
module ysyx_23060025_axi_sram_resp #(
  parameter int                  DATA_LEN  = 32,
  parameter int                  ADDR_LEN  = 32,
  parameter int                  DEPTH     = 1024,
  parameter logic [ADDR_LEN-1:0] BASE_ADDR = 32'h8000_0000,
  parameter int                  LATENCY   = 1
) (
  input  logic                clock,
  input  logic                rstn,
  input  logic [ADDR_LEN-1:0] addr_r_addr_i,
  input  logic [2:0]          addr_r_size_i,
  input  logic                addr_r_valid_i,
  output logic                addr_r_ready_o,
  output logic [DATA_LEN-1:0] r_data_o,
  output logic [1:0]          r_resp_o,
  output logic                r_valid_o,
  input  logic                r_ready_i,
  input  logic [ADDR_LEN-1:0] addr_w_addr_i,
  input  logic [2:0]          addr_w_size_i,
  input  logic                addr_w_valid_i,
  output logic                addr_w_ready_o,
  input  logic [DATA_LEN-1:0] w_data_i,
  input  logic [3:0]          w_strb_i,
  input  logic                w_valid_i,
  output logic                w_ready_o,
  output logic [1:0]          bkwd_resp_o,
  output logic                bkwd_valid_o,
  input  logic                bkwd_ready_i
);

  // Handshake rule on every channel: a transfer happens on the rising edge where
  // valid and ready are both 1; valid, once raised, stays up until that edge.

  localparam int                  IDX_W = $clog2(DEPTH);
  localparam logic [ADDR_LEN-1:0] SPAN  = ADDR_LEN'(4 * DEPTH);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    R_WAIT    = 3'd1,
    R_RESP    = 3'd2,
    W_COLLECT = 3'd3,
    W_WAIT    = 3'd4,
    W_RESP    = 3'd5
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;

  logic [DATA_LEN-1:0] r_mem [DEPTH];
  logic [ADDR_LEN-1:0] r_addr;
  logic [2:0]          r_size;
  logic [DATA_LEN-1:0] r_wdata;
  logic [3:0]          r_wstrb;
  logic                r_have_aw;
  logic                r_have_w;
  logic [3:0]          r_cnt;
  logic [3:0]          r_lat;

  logic                w_ar_fire;
  logic                w_aw_fire;
  logic                w_w_fire;
  logic                w_enter_wait;
  logic                w_wait_done;
  logic [ADDR_LEN-1:0] w_off;
  logic                w_in_range;
  logic [IDX_W-1:0]    w_idx;
  logic [3:0]          w_span_end;
  logic                w_err;
  logic [DATA_LEN-1:0] w_rd_word;
  logic [3:0]          w_lat_src;
  logic                w_idle_ok;

  assign w_ar_fire    = addr_r_valid_i & addr_r_ready_o;
  assign w_aw_fire    = addr_w_valid_i & addr_w_ready_o;
  assign w_w_fire     = w_valid_i & w_ready_o;
  assign w_enter_wait = ((w_state_nxt == R_WAIT) || (w_state_nxt == W_WAIT)) && (w_state_nxt != r_state);
  assign w_wait_done  = (r_cnt == r_lat);

  // Decode of the captured address; reads and writes share one address register.
  assign w_off      = r_addr - BASE_ADDR;
  assign w_in_range = (r_addr >= BASE_ADDR) && (w_off < SPAN);
  assign w_idx      = IDX_W'(w_off >> 2);
  assign w_span_end = {2'b00, r_addr[1:0]} + (4'd1 << r_size[1:0]);
  assign w_err      = !w_in_range || (r_size > 3'd2) || (w_span_end > 4'd4);
  assign w_rd_word  = r_mem[w_idx];

`ifdef SRAM_RAND_DELAY_EN
  logic [3:0] r_lfsr;
  logic [1:0] r_idle_cnt;
  logic       w_resp_done;

  assign w_resp_done = (r_state == R_RESP && r_ready_i) || (r_state == W_RESP && bkwd_ready_i);

  // x^4 + x^3 + 1 Fibonacci LFSR, stepped once per accepted request.
  always_ff @(posedge clock) begin
    if (!rstn) begin
      r_lfsr     <= 4'b0001;
      r_idle_cnt <= 2'd0;
    end else begin
      if (w_enter_wait) r_lfsr <= {r_lfsr[2:0], r_lfsr[3] ^ r_lfsr[2]};
      if (w_resp_done) r_idle_cnt <= r_lfsr[1:0];
      else if (r_state == IDLE && r_idle_cnt != 2'd0) r_idle_cnt <= r_idle_cnt - 2'd1;
    end
  end

  assign w_lat_src = r_lfsr;
  assign w_idle_ok = (r_idle_cnt == 2'd0);
`else
  assign w_lat_src = 4'(LATENCY);
  assign w_idle_ok = 1'b1;
`endif

  always_ff @(posedge clock) begin
    if (!rstn) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (w_ar_fire)                  w_state_nxt = R_WAIT;
        else if (w_aw_fire && w_w_fire) w_state_nxt = W_WAIT;
        else if (w_aw_fire || w_w_fire) w_state_nxt = W_COLLECT;
      end
      R_WAIT:    if (w_wait_done) w_state_nxt = R_RESP;
      R_RESP:    if (r_ready_i) w_state_nxt = IDLE;
      W_COLLECT: if (w_aw_fire || w_w_fire) w_state_nxt = W_WAIT;
      W_WAIT:    if (w_wait_done) w_state_nxt = W_RESP;
      W_RESP:    if (bkwd_ready_i) w_state_nxt = IDLE;
      default:   w_state_nxt = IDLE;
    endcase
  end

  // Read priority: a read arriving with a write drops both write readies in IDLE.
  always_comb begin
    addr_r_ready_o = 1'b0;
    addr_w_ready_o = 1'b0;
    w_ready_o      = 1'b0;
    r_valid_o      = 1'b0;
    bkwd_valid_o   = 1'b0;
    case (r_state)
      IDLE: begin
        addr_r_ready_o = w_idle_ok;
        addr_w_ready_o = w_idle_ok & ~addr_r_valid_i;
        w_ready_o      = w_idle_ok & ~addr_r_valid_i;
      end
      W_COLLECT: begin
        addr_w_ready_o = ~r_have_aw;
        w_ready_o      = ~r_have_w;
      end
      R_RESP:  r_valid_o    = 1'b1;
      W_RESP:  bkwd_valid_o = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!rstn) begin
      r_addr      <= '0;
      r_size      <= '0;
      r_wdata     <= '0;
      r_wstrb     <= '0;
      r_have_aw   <= 1'b0;
      r_have_w    <= 1'b0;
      r_cnt       <= '0;
      r_lat       <= '0;
      r_data_o    <= '0;
      r_resp_o    <= '0;
      bkwd_resp_o <= '0;
    end else begin
      if (w_ar_fire) begin
        r_addr <= addr_r_addr_i;
        r_size <= addr_r_size_i;
      end
      if (w_aw_fire) begin
        r_addr    <= addr_w_addr_i;
        r_size    <= addr_w_size_i;
        r_have_aw <= 1'b1;
      end
      if (w_w_fire) begin
        r_wdata  <= w_data_i;
        r_wstrb  <= w_strb_i;
        r_have_w <= 1'b1;
      end
      if (w_state_nxt == W_WAIT) begin
        r_have_aw <= 1'b0;
        r_have_w  <= 1'b0;
      end
      if (w_enter_wait) begin
        r_cnt <= '0;
        r_lat <= w_lat_src;
      end else if ((r_state == R_WAIT || r_state == W_WAIT) && !w_wait_done) begin
        r_cnt <= r_cnt + 4'd1;
      end
      if (r_state == R_WAIT && w_wait_done) begin
        r_data_o <= w_err ? '0 : w_rd_word;
        r_resp_o <= w_err ? 2'b10 : 2'b00;
      end
      if (r_state == W_WAIT && w_wait_done) bkwd_resp_o <= w_err ? 2'b10 : 2'b00;
    end
  end

  // Array is not reset; the write lands in the first W_WAIT cycle.
  always_ff @(posedge clock) begin
    if (rstn && r_state == W_WAIT && r_cnt == 4'd0 && !w_err) begin
      for (int i = 0; i < 4; i++) begin
        if (r_wstrb[i]) r_mem[w_idx][8*i +: 8] <= r_wdata[8*i +: 8];
      end
    end
  end

endmodule
